// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, shift kinds and NZCV flag layout.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_ORR = 4'b0011,
      OP_EOR = 4'b0100,
      OP_LSL = 4'b0101,
      OP_LSR = 4'b0110,
      OP_ASR = 4'b0111,
      OP_MUL = 4'b1000
   } op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DONE     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'd0,
      SH_LSR = 2'd1,
      SH_ASR = 2'd2
   } shift_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   function automatic shift_e shift_kind(input op_e op);
      case (op)
         OP_LSL:  return SH_LSL;
         OP_LSR:  return SH_LSR;
         default: return SH_ASR;
      endcase
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter (LSL/LSR/ASR) with ARM-style carry-out; zero latency, no flow control.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [7:0]       amt,
   input  shift_e           kind,
   input  logic             c_in,
   output logic [WIDTH-1:0] res,
   output logic             c_out
);

   logic [WIDTH-1:0] part;
   logic [7:0]       amt_m1;

   // Shift by amt-1 first so the last bit shifted out sits at an edge of part.
   always_comb begin
      amt_m1 = amt - 8'd1;
      part   = a;
      res    = a;
      c_out  = c_in;
      if (amt == 8'd0) begin
         res   = a;
         c_out = c_in;
      end else if (int'(amt) > WIDTH) begin
         if (kind == SH_ASR) begin
            res   = {WIDTH{a[WIDTH-1]}};
            c_out = a[WIDTH-1];
         end else begin
            res   = '0;
            c_out = 1'b0;
         end
      end else begin
         case (kind)
            SH_LSL: begin
               part  = a << amt_m1;
               res   = part << 1;
               c_out = part[WIDTH-1];
            end
            SH_LSR: begin
               part  = a >> amt_m1;
               res   = part >> 1;
               c_out = part[0];
            end
            default: begin
               part  = $signed(a) >>> amt_m1;
               res   = $signed(part) >>> 1;
               c_out = part[0];
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete in 1 cycle, shift-add MUL in WIDTH+1; NZCV commit register.
// Result/flags held in DONE until out_ready; in_ready is low while a MUL iterates.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       alu_flags,
   output logic [3:0]       flags_q
);

   state_e           state, state_nxt;
   op_e              op_in;
   logic             accept;
   logic             in_is_mul;
   logic             mul_last;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic             mul_sf;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] sh_res;
   logic             sh_c;
   logic [WIDTH-1:0] mul_step;
   nzcv_t            alu_flg;
   nzcv_t            mul_flg;

   assign op_in     = op_e'(op);
   assign in_is_mul = (op_in == OP_MUL);
   assign accept    = in_valid & in_ready;
   assign mul_last  = (state == MUL_BUSY) && (cnt == SHW'(WIDTH - 1));

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .a     (src_a),
      .amt   (src_b[7:0]),
      .kind  (shift_kind(op_in)),
      .c_in  (flags_q[FLAG_C]),
      .res   (sh_res),
      .c_out (sh_c)
   );

   // Single-cycle ops are evaluated from the live request in the accept cycle,
   // so preserved C/V come from flags_q as committed by the preceding op.
   always_comb begin
      b_eff     = (op_in == OP_SUB) ? ~src_b : src_b;
      sum       = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_in == OP_SUB};
      alu_res   = '0;
      alu_flg.n = 1'b0;
      alu_flg.z = 1'b0;
      alu_flg.c = flags_q[FLAG_C];
      alu_flg.v = flags_q[FLAG_V];
      case (op_in)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_flg.c = sum[WIDTH];
            alu_flg.v = (src_a[WIDTH-1] == src_b[WIDTH-1]) &
                        (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = sum[WIDTH-1:0];
            alu_flg.c = sum[WIDTH];
            alu_flg.v = (src_a[WIDTH-1] != src_b[WIDTH-1]) &
                        (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_AND: alu_res = src_a & src_b;
         OP_ORR: alu_res = src_a | src_b;
         OP_EOR: alu_res = src_a ^ src_b;
         OP_LSL, OP_LSR, OP_ASR: begin
            alu_res   = sh_res;
            alu_flg.c = sh_c;
         end
         OP_MUL: alu_res = '0;
         default: begin
            alu_flg.c = 1'b0;
            alu_flg.v = 1'b0;
         end
      endcase
      alu_flg.n = alu_res[WIDTH-1];
      alu_flg.z = (alu_res == '0);
   end

   always_comb begin
      mul_step  = acc + (mplier[0] ? mcand : '0);
      mul_flg.n = mul_step[WIDTH-1];
      mul_flg.z = (mul_step == '0);
      mul_flg.c = flags_q[FLAG_C];
      mul_flg.v = flags_q[FLAG_V];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = in_is_mul ? MUL_BUSY : DONE;
         end
         MUL_BUSY: begin
            if (mul_last) state_nxt = DONE;
         end
         DONE: begin
            if (accept)         state_nxt = in_is_mul ? MUL_BUSY : DONE;
            else if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         mul_sf    <= 1'b0;
         result    <= '0;
         alu_flags <= '0;
         flags_q   <= '0;
      end else begin
         if (accept && !in_is_mul) begin
            result    <= alu_res;
            alu_flags <= alu_flg;
            if (set_flags) flags_q <= alu_flg;
         end
         if (accept && in_is_mul) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
            mul_sf <= set_flags;
         end
         // One multiplier bit per cycle, LSB first; the multiplicand walks left.
         if (state == MUL_BUSY) begin
            acc    <= mul_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (mul_last) begin
               result    <= mul_step;
               alu_flags <= mul_flg;
               if (mul_sf) flags_q <= mul_flg;
            end
         end
      end
   end

endmodule
